// File: rtl/predecode_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : predecode_queue_pkg
//  Description : Shared RV32I opcode/funct3 constants, branch/LSU op types
//                and the pre-decode record carried by each queue entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package predecode_queue_pkg;

    // RV32I major opcodes
    localparam logic [6:0] opcode_lui      = 7'b0110111;
    localparam logic [6:0] opcode_auipc    = 7'b0010111;
    localparam logic [6:0] opcode_jal      = 7'b1101111;
    localparam logic [6:0] opcode_jalr     = 7'b1100111;
    localparam logic [6:0] opcode_branch   = 7'b1100011;
    localparam logic [6:0] opcode_load     = 7'b0000011;
    localparam logic [6:0] opcode_store    = 7'b0100011;
    localparam logic [6:0] opcode_op_imm   = 7'b0010011;
    localparam logic [6:0] opcode_op       = 7'b0110011;
    localparam logic [6:0] opcode_misc_mem = 7'b0001111;
    localparam logic [6:0] opcode_system   = 7'b1110011;

    // funct3 encodings
    localparam logic [2:0] funct3_beq     = 3'b000;
    localparam logic [2:0] funct3_bne     = 3'b001;
    localparam logic [2:0] funct3_blt     = 3'b100;
    localparam logic [2:0] funct3_bge     = 3'b101;
    localparam logic [2:0] funct3_bltu    = 3'b110;
    localparam logic [2:0] funct3_bgeu    = 3'b111;
    localparam logic [2:0] funct3_lb_sb   = 3'b000;
    localparam logic [2:0] funct3_lh_sh   = 3'b001;
    localparam logic [2:0] funct3_lw_sw   = 3'b010;
    localparam logic [2:0] funct3_lbu     = 3'b100;
    localparam logic [2:0] funct3_lhu     = 3'b101;
    localparam logic [2:0] funct3_fence_i = 3'b001;

    typedef enum logic [2:0] {
        BCU_NONE = 3'd0,
        BCU_BEQ  = 3'd1,
        BCU_BNE  = 3'd2,
        BCU_BLT  = 3'd3,
        BCU_BGE  = 3'd4,
        BCU_BLTU = 3'd5,
        BCU_BGEU = 3'd6
    } bcu_op_type;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_op_type;

    typedef struct packed {
        logic [31:0] imm;
        logic        wren;
        logic        rden1;
        logic        rden2;
        logic        lui;
        logic        auipc;
        logic        jal;
        logic        jalr;
        logic        branch;
        logic        load;
        logic        store;
        logic        alu;
        logic        system;
        logic        fence_i;
        bcu_op_type  bcu_op;
        lsu_op_type  lsu_op;
        logic        illegal;
    } pdq_info_t;

    // Branch comparison selected by funct3; reserved encodings map to NONE
    function automatic bcu_op_type init_bcu_op(input logic [2:0] funct3);
        case (funct3)
            funct3_beq:  return BCU_BEQ;
            funct3_bne:  return BCU_BNE;
            funct3_blt:  return BCU_BLT;
            funct3_bge:  return BCU_BGE;
            funct3_bltu: return BCU_BLTU;
            funct3_bgeu: return BCU_BGEU;
            default:     return BCU_NONE;
        endcase
    endfunction

    // Memory access size/sign selected by funct3; reserved encodings map to NONE
    function automatic lsu_op_type init_lsu_op(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            case (funct3)
                funct3_lb_sb: return LSU_SB;
                funct3_lh_sh: return LSU_SH;
                funct3_lw_sw: return LSU_SW;
                default:      return LSU_NONE;
            endcase
        end
        case (funct3)
            funct3_lb_sb: return LSU_LB;
            funct3_lh_sh: return LSU_LH;
            funct3_lw_sw: return LSU_LW;
            funct3_lbu:   return LSU_LBU;
            funct3_lhu:   return LSU_LHU;
            default:      return LSU_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/predecode_queue_lane.sv
`default_nettype none
// ============================================================================
//  Module      : predecode_lane
//  Description : Combinational RV32I pre-decoder for one fetch lane; produces
//                the pre-decode record and the early pc+imm target.
//  Revision    : 1.0 - initial release
// ============================================================================
module predecode_lane
    import predecode_queue_pkg::*;
#(
    parameter int PCW = 32
) (
    input  logic [31:0]    instr,
    input  logic [PCW-1:0] pc,
    output pdq_info_t      info,
    output logic [PCW-1:0] target
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_rd_nz;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_rd_nz  = (instr[11:7] != 5'd0);
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_imm_u  = {instr[31:12], 12'd0};

    // Opcode classification, immediate selection and legality
    always_comb begin
        info = '0;
        case (w_opcode)
            opcode_lui: begin
                info.lui  = 1'b1;
                info.imm  = w_imm_u;
                info.wren = w_rd_nz;
            end
            opcode_auipc: begin
                info.auipc = 1'b1;
                info.imm   = w_imm_u;
                info.wren  = w_rd_nz;
            end
            opcode_jal: begin
                info.jal  = 1'b1;
                info.imm  = w_imm_j;
                info.wren = w_rd_nz;
            end
            opcode_jalr: begin
                info.jalr  = 1'b1;
                info.imm   = w_imm_i;
                info.wren  = w_rd_nz;
                info.rden1 = 1'b1;
            end
            opcode_branch: begin
                info.branch  = 1'b1;
                info.imm     = w_imm_b;
                info.rden1   = 1'b1;
                info.rden2   = 1'b1;
                info.bcu_op  = init_bcu_op(w_funct3);
                info.illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            opcode_load: begin
                info.load    = 1'b1;
                info.imm     = w_imm_i;
                info.wren    = w_rd_nz;
                info.rden1   = 1'b1;
                info.lsu_op  = init_lsu_op(1'b0, w_funct3);
                info.illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                               (w_funct3 == 3'b111);
            end
            opcode_store: begin
                info.store   = 1'b1;
                info.imm     = w_imm_s;
                info.rden1   = 1'b1;
                info.rden2   = 1'b1;
                info.lsu_op  = init_lsu_op(1'b1, w_funct3);
                info.illegal = (w_funct3 >= 3'b011);
            end
            opcode_op_imm: begin
                info.alu   = 1'b1;
                info.imm   = w_imm_i;
                info.wren  = w_rd_nz;
                info.rden1 = 1'b1;
            end
            opcode_op: begin
                info.alu   = 1'b1;
                info.wren  = w_rd_nz;
                info.rden1 = 1'b1;
                info.rden2 = 1'b1;
            end
            opcode_misc_mem: begin
                // Plain fence carries no flags; only fence.i is distinguished
                info.imm     = w_imm_i;
                info.fence_i = (w_funct3 == funct3_fence_i);
            end
            opcode_system: begin
                info.system = 1'b1;
                info.imm    = w_imm_i;
            end
            default: info.illegal = 1'b1;
        endcase
        // Compressed/non-32-bit encodings are never valid here
        if (instr[1:0] != 2'b11) begin
            info.illegal = 1'b1;
        end
    end

    assign target = pc + PCW'($signed(info.imm));

endmodule
`default_nettype wire

// File: rtl/predecode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : predecode_queue
//  Description : Multi-lane RV32I pre-decode with an elastic circular queue
//                between fetch and decode; valid lanes are compacted in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module predecode_queue
    import predecode_queue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int PCW   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_mask,
    input  logic [PCW-1:0]         in_pc,
    input  logic [32*LANES-1:0]    in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PCW-1:0]         out_pc,
    output logic [31:0]            out_instr,
    output pdq_info_t              out_info,
    output logic [PCW-1:0]         out_target,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PCW-1:0] w_lane_pc     [LANES];
    logic [31:0]    w_lane_instr  [LANES];
    pdq_info_t      w_lane_info   [LANES];
    logic [PCW-1:0] w_lane_target [LANES];
    logic [AW-1:0]  w_waddr       [LANES];
    logic [CW-1:0]  w_push_cnt;
    logic [CW-1:0]  w_free;
    logic           w_push;
    logic           w_pop;

    logic [PCW-1:0] r_pc_mem     [DEPTH];
    logic [31:0]    r_instr_mem  [DEPTH];
    pdq_info_t      r_info_mem   [DEPTH];
    logic [PCW-1:0] r_target_mem [DEPTH];
    logic [AW-1:0]  r_rptr;
    logic [AW-1:0]  r_wptr;
    logic [CW-1:0]  r_count;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_lane_pc[k]    = in_pc + PCW'(4 * k);
            assign w_lane_instr[k] = in_instr[32*k +: 32];
            predecode_lane #(
                .PCW (PCW)
            ) u_lane (
                .instr  (w_lane_instr[k]),
                .pc     (w_lane_pc[k]),
                .info   (w_lane_info[k]),
                .target (w_lane_target[k])
            );
        end
    endgenerate

    // Prefix popcount of the mask gives each set lane its slot after wptr
    always_comb begin : p_compact
        logic [CW-1:0] acc;
        acc = '0;
        for (int k = 0; k < LANES; k++) begin
            w_waddr[k] = r_wptr + acc[AW-1:0];
            acc        = acc + CW'(in_mask[k]);
        end
        w_push_cnt = acc;
    end

    // Admission uses the current occupancy only; a same-cycle pop gives no credit
    assign w_free    = CW'(DEPTH) - r_count;
    assign in_ready  = (w_free >= CW'(LANES));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    // Entry storage: set lanes written to consecutive slots; flush leaves contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]     <= '0;
                r_instr_mem[i]  <= '0;
                r_info_mem[i]   <= '0;
                r_target_mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (w_push && in_mask[k]) begin
                    r_pc_mem[w_waddr[k]]     <= w_lane_pc[k];
                    r_instr_mem[w_waddr[k]]  <= w_lane_instr[k];
                    r_info_mem[w_waddr[k]]   <= w_lane_info[k];
                    r_target_mem[w_waddr[k]] <= w_lane_target[k];
                end
            end
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + w_push_cnt[AW-1:0];
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (w_push ? w_push_cnt : '0) - CW'(w_pop);
        end
    end

    assign out_pc     = r_pc_mem[r_rptr];
    assign out_instr  = r_instr_mem[r_rptr];
    assign out_info   = r_info_mem[r_rptr];
    assign out_target = r_target_mem[r_rptr];
    assign count      = r_count;

endmodule
`default_nettype wire
